// File: rtl/riscv_pkg.sv
// Shared types for the riscv memory-side blocks.
// Holds the arbiter state encoding, the NOP constant and the pending data request record.
// Widths here are the core's native XLEN; modules cast to their own parameters.
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int XMASK_W  = XLEN / 8;

   // addi x0, x0, 0 -- what the core sees before the first fetch lands
   localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } arb_state_t;

   // One captured load/store waiting for the bus
   typedef struct packed {
      logic [XLEN-1:0]    addr;
      logic [XLEN-1:0]    wdata;
      logic [XMASK_W-1:0] wmask;
      logic               we;
   } dmem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Purpose: shares one single-ported memory bus between instruction fetch and data access, drives core stall.
// Latency: fetch miss stalls >= 2 cycles, load/store completes >= 3 cycles after its pulse; +1 per bus wait state.
// Backpressure: core is held by O_stall; a data pulse while the slot is busy is dropped and flagged on O_overrun.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [DATA_W-1:0] RESET_INSTR = DATA_W'(RISCV_NOP)
) (
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   // fetch side
   input  logic [ADDR_W-1:0]     I_imem_addr,
   output logic [DATA_W-1:0]     O_imem_data,
   // data side
   input  logic [ADDR_W-1:0]     I_dmem_addr,
   input  logic [DATA_W-1:0]     I_dmem_wdata,
   input  logic [DATA_W/8-1:0]   I_dmem_wmask,
   input  logic                  I_dmem_rd,
   input  logic                  I_dmem_we,
   output logic [DATA_W-1:0]     O_dmem_rdata,
   // core stall
   output logic                  O_stall,
   // memory bus
   output logic                  O_mem_req,
   output logic                  O_mem_we,
   output logic [ADDR_W-1:0]     O_mem_addr,
   output logic [DATA_W-1:0]     O_mem_wdata,
   output logic [DATA_W/8-1:0]   O_mem_wmask,
   input  logic                  I_mem_ack,
   input  logic [DATA_W-1:0]     I_mem_rdata,
   // sticky error
   output logic                  O_overrun
);

   localparam int MASK_W = DATA_W / 8;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   arb_state_t          state_q, state_d;

   logic                pend_v_q, pend_v_d;
   dmem_req_t           pend_q, pend_d;

   logic                tag_v_q, tag_v_d;
   logic [ADDR_W-1:0]   tag_addr_q, tag_addr_d;

   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;

   logic [DATA_W-1:0]   imem_data_q, imem_data_d;
   logic [DATA_W-1:0]   dmem_rdata_q, dmem_rdata_d;
   logic                overrun_q, overrun_d;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic                fetch_need;
   logic                dmem_pulse;
   logic                slot_busy;
   logic                slot_consume;
   logic                bus_ack;
   logic                store_hits_tag;

   // The current fetch address misses when nothing is cached or it moved.
   assign fetch_need     = !tag_v_q || (I_imem_addr != tag_addr_q);
   assign dmem_pulse     = I_dmem_rd || I_dmem_we;
   // Only one data request may be queued or in flight at a time.
   assign slot_busy      = pend_v_q || (state_q == DATA);
   // Data wins arbitration, so a full slot always leaves IDLE for DATA.
   assign slot_consume   = (state_q == IDLE) && pend_v_q;
   // Ack only means something while a request is on the bus.
   assign bus_ack        = I_mem_ack && (state_q != IDLE);
   // Stores over the cached instruction word force a refetch.
   assign store_hits_tag = mem_we_q && tag_v_q && (mem_addr_q == tag_addr_q);

   // ------------------------------------------------------------------
   // Arbitration FSM, bus launch and response capture
   // ------------------------------------------------------------------
   // Next-state for the FSM, the launched bus fields and the returned words.
   always_comb begin
      state_d      = state_q;
      tag_v_d      = tag_v_q;
      tag_addr_d   = tag_addr_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      imem_data_d  = imem_data_q;
      dmem_rdata_d = dmem_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (pend_v_q) begin
               state_d     = DATA;
               mem_we_d    = pend_q.we;
               mem_addr_d  = ADDR_W'(pend_q.addr);
               mem_wdata_d = DATA_W'(pend_q.wdata);
               mem_wmask_d = MASK_W'(pend_q.wmask);
            end else if (fetch_need) begin
               // Address captured here is the one the tag will hold on return.
               state_d     = FETCH;
               mem_we_d    = 1'b0;
               mem_addr_d  = I_imem_addr;
               mem_wdata_d = '0;
               mem_wmask_d = '1;
            end
         end

         FETCH: begin
            if (bus_ack) begin
               state_d     = IDLE;
               imem_data_d = I_mem_rdata;
               tag_addr_d  = mem_addr_q;
               tag_v_d     = 1'b1;
            end
         end

         DATA: begin
            if (bus_ack) begin
               state_d = IDLE;
               if (!mem_we_q) begin
                  dmem_rdata_d = I_mem_rdata;
               end
               if (store_hits_tag) begin
                  tag_v_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pending data slot
   // ------------------------------------------------------------------
   // Capture a load/store pulse into the one-entry slot, or flag it as lost.
   always_comb begin
      pend_v_d  = pend_v_q;
      pend_d    = pend_q;
      overrun_d = overrun_q;

      if (slot_consume) begin
         pend_v_d = 1'b0;
      end

      if (dmem_pulse) begin
         if (slot_busy) begin
            overrun_d = 1'b1;
         end else begin
            pend_v_d     = 1'b1;
            pend_d.addr  = XLEN'(I_dmem_addr);
            pend_d.wdata = XLEN'(I_dmem_wdata);
            pend_d.wmask = XMASK_W'(I_dmem_wmask);
            // rd and we together resolve to a store
            pend_d.we    = I_dmem_we;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // FSM state; async reset abandons any in-flight bus request.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Pending slot and sticky overrun flag.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         pend_v_q  <= 1'b0;
         pend_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         pend_v_q  <= pend_v_d;
         pend_q    <= pend_d;
         overrun_q <= overrun_d;
      end
   end

   // Fetch tag: address of the word currently presented on O_imem_data.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         tag_v_q    <= 1'b0;
         tag_addr_q <= '0;
      end else begin
         tag_v_q    <= tag_v_d;
         tag_addr_q <= tag_addr_d;
      end
   end

   // Bus command fields, held constant for the whole request.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
      end
   end

   // Returned instruction and load words.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         imem_data_q  <= RESET_INSTR;
         dmem_rdata_q <= '0;
      end else begin
         imem_data_q  <= imem_data_d;
         dmem_rdata_q <= dmem_rdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign O_mem_req    = (state_q != IDLE);
   assign O_mem_we     = mem_we_q;
   assign O_mem_addr   = mem_addr_q;
   assign O_mem_wdata  = mem_wdata_q;
   assign O_mem_wmask  = mem_wmask_q;
   assign O_imem_data  = imem_data_q;
   assign O_dmem_rdata = dmem_rdata_q;
   assign O_overrun    = overrun_q;
   // Held low during reset; the empty tag raises it as soon as reset lifts.
   assign O_stall      = I_rst_n && ((state_q != IDLE) || pend_v_q || fetch_need);

endmodule
